// File: rtl/req_gnt_reg_target.sv
// rtl/req_gnt_reg_target.sv - req/gnt responder with a small writable/readable register window
module req_gnt_reg_target #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MIN_ADDR = 1,
  parameter int MAX_ADDR = 5,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              gnt,
  input  logic              ce,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int DEPTH = MAX_ADDR - MIN_ADDR + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic              gnt_q;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              in_win, accept, wr_hit, rd_hit, err_ev;
  logic [ADDR_W-1:0] offs;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req)  state_d = GRANT;
      GRANT:   if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accesses are qualified by the registered grant, so the cycle req drops still accepts.
  assign in_win = (addr >= ADDR_W'(MIN_ADDR)) && (addr <= ADDR_W'(MAX_ADDR));
  assign offs   = addr - ADDR_W'(MIN_ADDR);
  assign accept = ce & gnt_q;
  assign wr_hit = accept & wr & in_win;
  assign rd_hit = accept & ~wr;
  assign err_ev = ce & (~gnt_q | ~in_win);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (in_win && offs == ADDR_W'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    rdata_d   = rdata_q;
    if (rd_hit) rdata_d = rd_word;
    rvalid_d  = rd_hit;
    err_d     = err_ev;
    wr_cnt_d  = (wr_hit && wr_cnt_q != '1) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;
    err_cnt_d = (err_ev && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= (state_d == GRANT);
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit && offs == ADDR_W'(i)) regs_q[i] <= data;
      end
    end
  end

  assign gnt     = gnt_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign err     = err_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
